// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } bcd_state_e;

  localparam int unsigned BCD_DIGIT_W = 4;

  // ceil(width * log10(2)); log10(2) ~= 0.30103, never an exact integer product for width > 0.
  function automatic int unsigned digits_needed(input int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Input/output handshake bundle between the adder result and the digit mux.
interface bcd_seq_converter_if #(
  parameter int unsigned BIN_W  = 9,
  parameter int unsigned DIGITS = 3
);
  import bcd_pkg::*;

  logic [BIN_W-1:0]              bin;
  logic                          in_valid;
  logic                          in_ready;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;
  logic                          sign;
  logic                          overflow;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output bin, in_valid, out_ready,
    input  in_ready, bcd, sign, overflow, out_valid
  );

  modport slave (
    input  bin, in_valid, out_ready,
    output in_ready, bcd, sign, overflow, out_valid
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Single-digit add-3 correction applied before each shift.
module bcd_digit_adj (
  input  logic [3:0] raw,
  output logic [3:0] adj
);

  assign adj = (raw >= 4'd5) ? raw + 4'd3 : raw;

endmodule

// File: rtl/bcd_seq_converter.sv
// Shift-and-add-3 binary-to-BCD converter, one bit per clock, with valid/ready on both sides.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 9,
  parameter int unsigned DIGITS = 3,
  parameter bit          SIGNED = 1'b0
) (
  input logic               clk,
  input logic               rst,
  bcd_seq_converter_if.slave bus
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  bcd_state_e       state_q, state_d;
  logic [BIN_W-1:0] shreg_q, shreg_d;
  logic [BCD_W-1:0] digits_q, digits_d;
  logic [BCD_W-1:0] digits_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sign_q, sign_d;
  logic             neg;
  logic [BIN_W-1:0] mag;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .raw (digits_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .adj (digits_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  // The most negative input maps onto 2^(BIN_W-1), which still fits unsigned.
  assign neg = SIGNED && bus.bin[BIN_W-1];
  assign mag = neg ? (~bus.bin) + BIN_W'(1) : bus.bin;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    sign_d   = sign_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          shreg_d  = mag;
          digits_d = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          sign_d   = neg;
          state_d  = StShift;
        end
      end
      StShift: begin
        digits_d = {digits_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
        shreg_d  = {shreg_q[BIN_W-2:0], 1'b0};
        ovf_d    = ovf_q | digits_adj[BCD_W-1];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      digits_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      digits_q <= digits_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      sign_q   <= sign_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.bcd       = digits_q;
  assign bus.overflow  = ovf_q;
  assign bus.sign      = sign_q;

endmodule

// File: doc/bcd_seq_converter.md
# bcd_seq_converter

Sequential, parametrised binary-to-BCD converter using shift-and-add-3, one shift per clock. It replaces the purely combinational 9-bit converter behind the BCD adder display path. It adds configurable input width and digit count, optional signed input, overflow detection and valid/ready handshakes on both sides. It sits between the binary adder result and the seven-segment digit mux.

## Interface
Parameters:
- BIN_W, default 9: input width in bits; the default covers an 8-bit sum plus carry. Legal range 2..32.
- DIGITS, default 3: number of BCD output digits. Legal range 1..10.
- SIGNED, default 0: when 1, `bin` is two's complement and the magnitude is converted.

Ports:
- clk, input, 1: the single clock. All state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- bin, input, BIN_W: value to convert. Sampled only on input acceptance.
- in_valid, input, 1: `bin` is valid.
- in_ready, output, 1: block can accept a value.
- bcd, output, 4*DIGITS: result digits. Digit 0 (units) is at [3:0], digit k is at [4k+3:4k].
- sign, output, 1: 1 when SIGNED=1 and the input was negative. Always 0 when SIGNED=0.
- overflow, output, 1: the magnitude is ≥ 10^DIGITS.
- out_valid, output, 1: `bcd`, `sign` and `overflow` are valid.
- out_ready, input, 1: consumer takes the result.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: load shift register with magnitude(bin); clear digit register, overflow and count; latch sign; go to SHIFT.
  - magnitude(bin) = bin if SIGNED=0 or bin[BIN_W-1]=0; otherwise the two's complement of bin, taken as unsigned BIN_W bits.
  - -2^(BIN_W-1) has magnitude 2^(BIN_W-1), which fits in BIN_W unsigned bits.
- **SHIFT**, one iteration per cycle:
  1. Every digit ≥ 5 gets +3. This is a 4-bit add, computed per digit from the pre-adjust value.
  2. Concatenate {digits, shift register} and shift left by 1.
  3. If the bit leaving the top of digit DIGITS-1 is 1, set overflow (sticky).
  4. count+1. After iteration BIN_W, go to DONE.
- **DONE**
  - out_valid=1; outputs hold stable.
  - On out_ready, go to IDLE. in_ready stays 0 in this cycle.
- On overflow, `bcd` equals magnitude mod 10^DIGITS; the lower digits are still exact.
- in_valid is ignored in SHIFT and DONE.
- out_ready is ignored outside DONE.
- The count register is sized clog2(BIN_W+1) bits.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state=IDLE; in_ready=1.
  - bcd=0, sign=0, overflow=0, out_valid=0.
  - Internal shift register and count are 0.
- Reset during SHIFT or DONE abandons the conversion. No out_valid is ever produced for it.
- Latency:
  - Acceptance happens at edge E0, when in_valid and in_ready are both 1.
  - Shifts occur at edges E1..E_BIN_W.
  - out_valid is 1 from just after E_BIN_W. Latency is BIN_W cycles.
- Maximum throughput: one result per BIN_W+2 cycles, with out_ready tied high and in_valid held high.
- Back-pressure: DONE may last any number of cycles; bcd, sign and overflow must not change while out_valid=1.
- `bcd` and `overflow` are registered outputs. Intermediate values may be visible during SHIFT, but they are valid only while out_valid=1.
- `bin` may change freely after acceptance.

## Structure
- Shared package `bcd_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE);
  - constant BCD_DIGIT_W = 4;
  - function `digits_needed(width)` = ceil(width·log10 2), for use by instantiating parents. The block itself does not enforce sufficiency.
- Sub-module `bcd_digit_adj`:
  - combinational, 4-bit in and 4-bit out: out = in ≥ 5 ? in+3 : in;
  - instantiated DIGITS times in a generate loop.
- Everything else (FSM, shift register, count, flags) lives in the top module.

## Test plan
- Defaults (BIN_W=9, DIGITS=3, SIGNED=0), bin=9'h1FF → after 9 cycles: out_valid=1, bcd=12'h511, overflow=0.
- Defaults, bin=0, then bin=9'd100 back-to-back with in_valid held high and out_ready high → bcd=12'h000 then 12'h100, with results 11 cycles apart.
- BIN_W=8, DIGITS=3, SIGNED=1:
  - bin=8'h80 → sign=1, bcd=12'h128.
  - bin=8'hFF → sign=1, bcd=12'h001.
  - bin=8'h7F → sign=0, bcd=12'h127.
- BIN_W=8, DIGITS=2, bin=8'd255 → bcd=8'h55, overflow=1. Then bin=8'd99 → bcd=8'h99, overflow=0.
- Defaults, bin=9'd345, out_ready=0 for 20 cycles after out_valid → outputs stable at 12'h345 and in_ready=0 throughout; out_ready=1 for one cycle → out_valid=0 and in_ready=1 on the next cycle.
- Defaults, bin=9'd256, assert rst for 1 cycle at the 4th SHIFT cycle → all outputs 0 and in_ready=1 at once; no out_valid follows. A new bin=9'd42 then gives bcd=12'h042.
